// File: rtl/bcinrd_pkg.sv
// Shared types and limits for the bank input-read-enable sequencer.
package bcinrd_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SETTLE = 1'b1
  } seq_state_t;

  localparam int IDLE_CNT_W       = 16;
  localparam int NUM_BANKS_MAX    = 8;
  localparam int SETTLE_MAX       = 255;
  localparam int IDLE_TIMEOUT_MAX = 65535;

endpackage

// File: rtl/bcinrd_bank_timer.sv
// Per-bank idle counter: counts request-low cycles while the bank is ready and
// flags the bank for turn-off once the count reaches IDLE_TIMEOUT.
module bcinrd_bank_timer
  import bcinrd_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req,
  input  logic i_rdy,
  output logic o_expire
);

  localparam logic [IDLE_CNT_W-1:0] TIMEOUT_VAL = IDLE_CNT_W'(IDLE_TIMEOUT);
  localparam bit                    TIMEOUT_EN  = (IDLE_TIMEOUT != 0);

  logic [IDLE_CNT_W-1:0] r_idle_cnt;

  // Expiry has priority over a request arriving in the same cycle.
  assign o_expire = TIMEOUT_EN && i_rdy && (r_idle_cnt == TIMEOUT_VAL);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idle_cnt <= '0;
    end else if (!TIMEOUT_EN || !i_rdy || i_req || o_expire) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + IDLE_CNT_W'(1);
    end
  end

endmodule

// File: rtl/bcinrd_seq.sv
// Inrush-limited sequencer: turns on one I/O bank input buffer at a time,
// waits SETTLE_CYCLES before flagging it ready, and auto-disables idle banks.
module bcinrd_seq
  import bcinrd_pkg::*;
#(
  parameter int NUM_BANKS     = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int IDLE_TIMEOUT  = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_BANKS-1:0] REQ,
  output logic [NUM_BANKS-1:0] INRDENI,
  output logic [NUM_BANKS-1:0] RDY,
  output logic                 BUSY
);

  localparam int               CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  if (NUM_BANKS < 1 || NUM_BANKS > NUM_BANKS_MAX) begin : g_bad_num_banks
    $error("bcinrd_seq: NUM_BANKS out of range 1..8");
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
    $error("bcinrd_seq: SETTLE_CYCLES out of range 1..255");
  end
  if (IDLE_TIMEOUT < 0 || IDLE_TIMEOUT > IDLE_TIMEOUT_MAX) begin : g_bad_timeout
    $error("bcinrd_seq: IDLE_TIMEOUT out of range 0..65535");
  end

  seq_state_t           r_state;
  seq_state_t           w_next_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [NUM_BANKS-1:0] r_sel;
  logic [NUM_BANKS-1:0] r_en;
  logic [NUM_BANKS-1:0] r_rdy;
  logic [NUM_BANKS-1:0] w_pend;
  logic [NUM_BANKS-1:0] w_pick;
  logic [NUM_BANKS-1:0] w_expire;
  logic                 w_start;
  logic                 w_done;

  // A bank being switched off this cycle still has its enable set, so it
  // cannot be re-selected until the following cycle.
  assign w_pend = REQ & ~r_en;
  assign w_pick = w_pend & (~w_pend + NUM_BANKS'(1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  // NOTE: every signal driven here gets a default first so no path through
  // the case leaves it unassigned and infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_start      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_pend) begin
          w_start      = 1'b1;
          w_cnt_next   = CNT_LOAD;
          w_next_state = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_done       = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sel <= '0;
      r_en  <= '0;
      r_rdy <= '0;
    end else begin
      if (w_start) begin
        r_sel <= w_pick;
      end
      r_en  <= (r_en & ~w_expire) | (w_start ? w_pick : '0);
      r_rdy <= (r_rdy & ~w_expire) | (w_done ? r_sel : '0);
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    bcinrd_bank_timer #(
      .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) u_timer (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_req   (REQ[g]),
      .i_rdy   (r_rdy[g]),
      .o_expire(w_expire[g])
    );
  end

  assign INRDENI = r_en;
  assign RDY     = r_rdy;
  assign BUSY    = (r_state == S_SETTLE);

endmodule
